dark_roi_scheduler: RTL and testbench

//  Sequences the dark-pixel counter across a table of NUM_WIN regions of interest, one window per frame.

---
 rtl/dark_roi_pkg.sv | 23 ++
 rtl/roi_frame_tracker.sv | 30 +++
 rtl/dark_roi_scheduler.sv | 125 ++++++++++++
 tb/tb_dark_roi_scheduler.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dark_roi_pkg.sv
// dark_roi_pkg: FSM states, window-table field selects and default frame geometry
// shared by the dark ROI scheduler and its frame tracker.
package dark_roi_pkg;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ARM  = 2'd1;
    localparam logic [1:0] ST_MEAS = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [1:0] SEL_XSTART = 2'd0;
    localparam logic [1:0] SEL_XEND   = 2'd1;
    localparam logic [1:0] SEL_YSTART = 2'd2;
    localparam logic [1:0] SEL_YEND   = 2'd3;

    localparam int DEF_H_ACT = 640;
    localparam int DEF_V_ACT = 480;

    typedef struct packed {
        logic [15:0] xstart;
        logic [15:0] xend;
        logic [15:0] ystart;
        logic [15:0] yend;
    } win_t;
endpackage

// File: rtl/roi_frame_tracker.sv
// roi_frame_tracker: X/Y position counters advanced by the pixel-valid strobe,
// producing last_px on the final pixel of each frame.
module roi_frame_tracker #(
    parameter int H_ACT = 640,
    parameter int V_ACT = 480
) (
    input  logic clk,
    input  logic rst_n,
    input  logic dval,
    output logic last_px
);
    logic [15:0] x;
    logic [15:0] y;
    logic        x_end;
    logic        y_end;

    assign x_end   = x == 16'(H_ACT - 1);
    assign y_end   = y == 16'(V_ACT - 1);
    assign last_px = dval && x_end && y_end;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            x <= '0;
            y <= '0;
        end else if (dval) begin
            x <= x_end ? '0 : x + 16'd1;
            if (x_end) y <= y_end ? '0 : y + 16'd1;
        end
    end
endmodule

// File: rtl/dark_roi_scheduler.sv
// dark_roi_scheduler: steps the dark-pixel counter through a table of windows, one per frame,
// and latches each window's frame count. Optional DARK_ALARM_EN adds iThresh/oAlarm.
module dark_roi_scheduler
    import dark_roi_pkg::*;
#(
    parameter int NUM_WIN = 4,
    parameter int H_ACT   = DEF_H_ACT,
    parameter int V_ACT   = DEF_V_ACT,
    localparam int WIN_W  = $clog2(NUM_WIN)
) (
    input  logic             iCLK,
    input  logic             iRST,
    input  logic             iDVAL,
    input  logic [15:0]      iDarkCounter,
    input  logic             iStart,
    input  logic             iAbort,
    input  logic             iCfgWe,
    input  logic [WIN_W-1:0] iCfgAddr,
    input  logic [1:0]       iCfgSel,
    input  logic [15:0]      iCfgData,
    input  logic [WIN_W-1:0] iRdIdx,
    output logic [15:0]      oRdCount,
    output logic [15:0]      oXSTART,
    output logic [15:0]      oXEND,
    output logic [15:0]      oYSTART,
    output logic [15:0]      oYEND,
    output logic             oBusy,
    output logic             oDone,
    output logic [WIN_W-1:0] oWinIdx
`ifdef DARK_ALARM_EN
    ,
    input  logic [15:0]      iThresh,
    output logic [NUM_WIN-1:0] oAlarm
`endif
);
    logic [1:0]       state;
    logic [WIN_W-1:0] win;
    logic [WIN_W-1:0] next_win;
    logic             last_px;
    logic             meas_hit;
    logic             last_win;
    win_t             cur;
    win_t             bounds;
    win_t             tbl [NUM_WIN];
    logic [15:0]      res [NUM_WIN];

    roi_frame_tracker #(.H_ACT(H_ACT), .V_ACT(V_ACT)) u_tracker (
        .clk(iCLK),
        .rst_n(iRST),
        .dval(iDVAL),
        .last_px(last_px)
    );

    assign next_win = win + WIN_W'(1);
    assign last_win = win == WIN_W'(NUM_WIN - 1);
    assign meas_hit = state == ST_MEAS && last_px && !iAbort;
    assign bounds   = state == ST_IDLE ? tbl[0] : cur;
    assign oXSTART  = bounds.xstart;
    assign oXEND    = bounds.xend;
    assign oYSTART  = bounds.ystart;
    assign oYEND    = bounds.yend;
    assign oBusy    = state == ST_ARM || state == ST_MEAS;
    assign oDone    = state == ST_DONE;
    assign oWinIdx  = win;
    assign oRdCount = res[iRdIdx];

    // Abort outranks every transition, so it is tested before the state case.
    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            state <= ST_IDLE;
            win   <= '0;
            cur   <= '0;
        end else if (iAbort) begin
            state <= ST_IDLE;
            win   <= '0;
        end else begin
            case (state)
                ST_IDLE: if (iStart) begin
                    state <= ST_ARM;
                    win   <= '0;
                    cur   <= tbl[0];
                end
                ST_ARM:  if (last_px) state <= ST_MEAS;
                ST_MEAS: if (last_px) begin
                    if (last_win) state <= ST_DONE;
                    else begin
                        win <= next_win;
                        cur <= tbl[next_win];
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    win   <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST) begin
            for (int i = 0; i < NUM_WIN; i++) begin
                tbl[i] <= '0;
                res[i] <= '0;
            end
        end else begin
            if (meas_hit) res[win] <= iDarkCounter;
            if (state == ST_IDLE && iCfgWe) begin
                case (iCfgSel)
                    SEL_XSTART: tbl[iCfgAddr].xstart <= iCfgData;
                    SEL_XEND:   tbl[iCfgAddr].xend   <= iCfgData;
                    SEL_YSTART: tbl[iCfgAddr].ystart <= iCfgData;
                    default:    tbl[iCfgAddr].yend   <= iCfgData;
                endcase
            end
        end
    end

`ifdef DARK_ALARM_EN
    always_ff @(posedge iCLK) begin
        if (!iRST) oAlarm <= '0;
        else if (state == ST_IDLE && iStart && !iAbort) oAlarm <= '0;
        else if (meas_hit) oAlarm[win] <= iDarkCounter > iThresh;
    end
`endif
endmodule

// File: tb/tb_dark_roi_scheduler.sv
// tb_dark_roi_scheduler: randomized sweeps on a small frame against a pixel-level model of the
// dark counter; expected window counts are enumerated directly from the window table.
module tb_dark_roi_scheduler;
    localparam int H = 32;
    localparam int V = 24;
    localparam int N = 4;

    logic        clk = 0, rst_n = 0, dval = 0, start = 0, abort = 0, we = 0;
    logic [1:0]  addr = 0, sel = 0, rd_idx = 0, win_idx;
    logic [15:0] wdata = 0, dark, rd_count, xs, xe, ys, ye;
    logic        busy, done;
`ifdef DARK_ALARM_EN
    logic [15:0]  thresh = 0;
    logic [N-1:0] alarm;
`endif

    int checks = 0, passed = 0, done_cnt = 0;
    int bx = 0, by = 0, frm = 0, cnt = 0;
    logic [15:0] sxs, sxe, sys, sye;
    logic [15:0] tbl_m [N][4];
    int          res_m [N];

    always #5 clk = ~clk;

    dark_roi_scheduler #(.NUM_WIN(N), .H_ACT(H), .V_ACT(V)) dut (
        .iCLK(clk), .iRST(rst_n), .iDVAL(dval), .iDarkCounter(dark),
        .iStart(start), .iAbort(abort), .iCfgWe(we), .iCfgAddr(addr),
        .iCfgSel(sel), .iCfgData(wdata), .iRdIdx(rd_idx), .oRdCount(rd_count),
        .oXSTART(xs), .oXEND(xe), .oYSTART(ys), .oYEND(ye),
        .oBusy(busy), .oDone(done), .oWinIdx(win_idx)
`ifdef DARK_ALARM_EN
        , .iThresh(thresh), .oAlarm(alarm)
`endif
    );

    function automatic bit is_dark(input int x, input int y, input int f);
        return ((x + y) % (f % 3 + 2)) == 0;
    endfunction

    function automatic int exp_count(input int k, input int f);
        int e = 0;
        for (int y = 0; y < V; y++)
            for (int x = 0; x < H; x++)
                if (!(x == H - 1 && y == V - 1) && int'(tbl_m[k][0]) < x && x < int'(tbl_m[k][1])
                    && int'(tbl_m[k][2]) < y && y < int'(tbl_m[k][3]) && is_dark(x, y, f)) e++;
        return e;
    endfunction

    function automatic bit rnd();
        return $urandom_range(0, 3) != 0;
    endfunction

    // Dark-counter model: counts dark pixels inside the bounds it is driven with, clears on the last pixel.
    always @(negedge clk) begin
        sxs <= xs; sxe <= xe; sys <= ys; sye <= ye;
    end
    assign dark = 16'(cnt);
    always @(posedge clk) begin
        if (!rst_n) begin
            bx <= 0; by <= 0; frm <= 0; cnt <= 0;
        end else if (dval) begin
            if (bx == H - 1 && by == V - 1) begin
                bx <= 0; by <= 0; frm <= frm + 1; cnt <= 0;
            end else begin
                bx <= (bx == H - 1) ? 0 : bx + 1;
                if (bx == H - 1) by <= by + 1;
                if (int'(sxs) < bx && bx < int'(sxe) && int'(sys) < by && by < int'(sye) && is_dark(bx, by, frm))
                    cnt <= cnt + 1;
            end
        end
    end

    task automatic cycle(input bit d, input bit s, input bit a);
        logic [63:0] pb;
        bit pbusy, lp;
        @(negedge clk);
        dval = d; start = s; abort = a;
        lp = d && bx == H - 1 && by == V - 1;
        pb = {xs, xe, ys, ye};
        pbusy = busy;
        @(posedge clk); #1;
        if (done) done_cnt++;
        if (pbusy && !a && {xs, xe, ys, ye} !== pb) begin
            checks++;
            if (!lp) $display("FAIL switch: bounds %h changed from %h without last_px", {xs, xe, ys, ye}, pb);
            else passed++;
        end
        we = 0; start = 0; abort = 0; dval = 0;
    endtask

    task automatic program_rand();
        logic [15:0] b [4];
        for (int k = 0; k < N; k++) begin
            b[0] = 16'($urandom_range(0, H - 3)); b[1] = 16'($urandom_range(int'(b[0]) + 2, H + 1));
            b[2] = 16'($urandom_range(0, V - 3)); b[3] = 16'($urandom_range(int'(b[2]) + 2, V + 1));
            for (int f = 0; f < 4; f++) begin
                we = 1; addr = 2'(k); sel = 2'(f); wdata = b[f];
                cycle(0, 0, 0);
                tbl_m[k][f] = b[f];
            end
        end
    endtask

    task automatic start_sweep(output int f0);
        repeat ($urandom_range(50, 700)) cycle(rnd(), 0, 0);
        f0 = frm;
        cycle(0, 1, 0);
        checks++;
        if ({busy, win_idx, xs} !== {1'b1, 2'd0, tbl_m[0][0]})
            $display("FAIL start: busy/win/xstart=%b/%0d/%0d expected 1/0/%0d", busy, win_idx, xs, tbl_m[0][0]);
        else passed++;
    endtask

    task automatic wait_done();
        int d0 = done_cnt;
        for (int i = 0; i < 12000 && done_cnt == d0; i++) cycle(rnd(), 0, 0);
        checks++;
        if (done_cnt == d0) $display("FAIL done_timeout: oDone=0 after 12000 cycles expected a pulse");
        else passed++;
    endtask

    task automatic check_results(input string tag, input int f0);
        for (int k = 0; k < N; k++) begin
            rd_idx = 2'(k); #1;
            checks++;
            if (int'(rd_count) !== exp_count(k, f0 + 1 + k))
                $display("FAIL %s_result%0d: got %0d expected %0d", tag, k, rd_count, exp_count(k, f0 + 1 + k));
            else passed++;
            res_m[k] = exp_count(k, f0 + 1 + k);
        end
    endtask

    task automatic test_reset();
        rst_n = 0;
        repeat (3) cycle(0, 0, 0);
        checks++;
        if ({busy, done, win_idx} !== 4'd0) $display("FAIL reset_ctrl: busy/done/win=%b%b%0d expected 0", busy, done, win_idx);
        else passed++;
        checks++;
        if ({xs, xe, ys, ye} !== 64'd0) $display("FAIL reset_bounds: %h expected 0", {xs, xe, ys, ye});
        else passed++;
        for (int k = 0; k < N; k++) begin
            rd_idx = 2'(k); #1;
            checks++;
            if (rd_count !== 16'd0) $display("FAIL reset_result%0d: got %0d expected 0", k, rd_count);
            else passed++;
        end
        rst_n = 1;
        for (int k = 0; k < N; k++) res_m[k] = 0;
    endtask

    task automatic test_sweep();
        int f0, d0;
        program_rand();
        d0 = done_cnt;
        start_sweep(f0);
        wait_done();
        repeat (5) cycle(rnd(), 0, 0);
        checks++;
        if (done_cnt - d0 !== 1 || busy !== 1'b0)
            $display("FAIL sweep_end: done pulses=%0d busy=%b expected 1 and 0", done_cnt - d0, busy);
        else passed++;
        check_results("sweep", f0);
    endtask

    task automatic test_cfg_during_meas();
        int f0;
        program_rand();
        start_sweep(f0);
        for (int i = 0; i < 5000 && win_idx != 2'd1; i++) cycle(rnd(), 0, 0);
        we = 1; addr = 2'd0; sel = 2'd0; wdata = tbl_m[0][0] ^ 16'h00ff;
        cycle(rnd(), 0, 0);
        we = 1; addr = 2'd2; sel = 2'd1; wdata = 16'd0;
        cycle(rnd(), 1, 0);
        wait_done();
        repeat (3) cycle(rnd(), 0, 0);
        check_results("cfg_meas", f0);
        checks++;
        if ({xs, xe, ys, ye} !== {tbl_m[0][0], tbl_m[0][1], tbl_m[0][2], tbl_m[0][3]})
            $display("FAIL cfg_readback: %h expected %h", {xs, xe, ys, ye},
                     {tbl_m[0][0], tbl_m[0][1], tbl_m[0][2], tbl_m[0][3]});
        else passed++;
    endtask

    task automatic test_abort();
        int f0, d0;
        bool_hit: begin end
        program_rand();
        d0 = done_cnt;
        start_sweep(f0);
        for (int i = 0; i < 6000; i++) begin
            if (win_idx == 2'd1 && bx == H - 1 && by == V - 1) begin
                cycle(1, 0, 1);
                break;
            end
            cycle(rnd(), 0, 0);
        end
        checks++;
        if (busy !== 1'b0) $display("FAIL abort_busy: got %b expected 0", busy);
        else passed++;
        repeat (2000) cycle(rnd(), 0, 0);
        checks++;
        if (done_cnt !== d0) $display("FAIL abort_done: %0d pulses expected 0", done_cnt - d0);
        else passed++;
        res_m[0] = exp_count(0, f0 + 1);
        for (int k = 0; k < N; k++) begin
            rd_idx = 2'(k); #1;
            checks++;
            if (int'(rd_count) !== res_m[k]) $display("FAIL abort_result%0d: got %0d expected %0d", k, rd_count, res_m[k]);
            else passed++;
        end
        cycle(0, 1, 1);
        checks++;
        if (busy !== 1'b0) $display("FAIL start_abort_idle: busy=%b expected 0", busy);
        else passed++;
    endtask

`ifdef DARK_ALARM_EN
    task automatic test_alarm();
        logic [N-1:0] ea;
        thresh = 16'($urandom_range(0, 120));
        test_sweep();
        for (int k = 0; k < N; k++) ea[k] = res_m[k] > int'(thresh);
        checks++;
        if (alarm !== ea) $display("FAIL alarm: got %b expected %b", alarm, ea);
        else passed++;
        cycle(0, 1, 0);
        checks++;
        if (alarm !== '0) $display("FAIL alarm_clear: got %b expected 0", alarm);
        else passed++;
        cycle(0, 0, 1);
    endtask
`endif

    initial begin
        test_reset();
        test_sweep();
        test_sweep();
        test_cfg_during_meas();
        test_abort();
`ifdef DARK_ALARM_EN
        test_alarm();
`endif
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
